pl_mem_wb: RTL and testbench

//  Final (MEM/WB) pipeline stage; consumes the EX-stage pipeline register outputs.

---
 rtl/pl_mem_wb.sv | 173 +++++++++++++++++
 tb/tb_pl_mem_wb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pl_mem_wb.sv
// MEM/WB pipeline stage: data-memory and I/O handshakes, register-file writeback,
// carry update and a watchdog that aborts accesses whose ready/ack never arrives.
module pl_mem_wb #(
    parameter int NUM_DOMAINS = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:9]               EX_reg,
    input  logic [NUM_DOMAINS*8-1:0] operation_result,
    input  logic [3:0]               destination_reg_addr,
    input  logic [15:0]              data_op_addr,
    input  logic [7:0]               IO_port_ID,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ready,
    input  logic [7:0]               io_rdata,
    input  logic                     io_ack,
    output logic [15:0]              mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [7:0]               io_port,
    output logic [7:0]               io_wdata,
    output logic                     io_wr_stb,
    output logic                     io_rd_stb,
    output logic                     rf_wr_en,
    output logic                     rf_wr_rns,
    output logic [2:0]               rf_wr_addr,
    output logic [NUM_DOMAINS*8-1:0] rf_wr_data,
    output logic                     carry_flag,
    output logic                     stall,
    output logic                     bus_err
);

    localparam int RW  = NUM_DOMAINS * 8;
    localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MEM_RD = 3'd1;
    localparam logic [2:0] S_MEM_WR = 3'd2;
    localparam logic [2:0] S_IO_RD  = 3'd3;
    localparam logic [2:0] S_IO_WR  = 3'd4;

    logic [2:0]     r_state;
    logic [WDW-1:0] r_wd;
    logic [3:0]     r_dest;

    logic w_store, w_regwr, w_save, w_kill, w_load, w_outp, w_inp;
    logic w_idle, w_acc, w_done, w_tmo;
    logic w_unused;

    assign w_store  = EX_reg[0];
    assign w_regwr  = EX_reg[1];
    assign w_save   = EX_reg[2];
    assign w_kill   = EX_reg[3];
    assign w_load   = EX_reg[4];
    assign w_outp   = EX_reg[8];
    assign w_inp    = EX_reg[9];
    // Fetch/decode invalidate flags and dest_RNS are consumed upstream; the RNS
    // select comes from destination_reg_addr[3].
    assign w_unused = ^{EX_reg[5], EX_reg[6], EX_reg[7]};

    function automatic logic [RW-1:0] zext8(input logic [7:0] b);
        logic [RW-1:0] v;
        v      = '0;
        v[7:0] = b;
        return v;
    endfunction

    assign w_idle = (r_state == S_IDLE);
    assign w_acc  = w_idle && !w_kill && (w_store || w_load || w_outp || w_inp);

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_MEM_RD, S_MEM_WR: w_done = mem_ready;
            S_IO_RD, S_IO_WR:   w_done = io_ack;
            default:            w_done = 1'b0;
        endcase
    end

    assign w_tmo = !w_idle && !w_done && (r_wd == WD_LAST);

    // Completion and abort cycles release upstream so the next op lands with no bubble.
    assign stall = !reset && (w_acc || (!w_idle && !w_done && !w_tmo));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wd       <= '0;
            r_dest     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            io_port    <= '0;
            io_wdata   <= '0;
            io_wr_stb  <= 1'b0;
            io_rd_stb  <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_wr_rns  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            carry_flag <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            rf_wr_en <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (!w_kill) begin
                        if (w_store) begin
                            r_state   <= S_MEM_WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= data_op_addr;
                            mem_wdata <= operation_result[7:0];
                        end else if (w_load) begin
                            r_state  <= S_MEM_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= data_op_addr;
                            r_dest   <= destination_reg_addr;
                        end else if (w_outp) begin
                            r_state   <= S_IO_WR;
                            io_wr_stb <= 1'b1;
                            io_port   <= IO_port_ID;
                            io_wdata  <= operation_result[7:0];
                        end else if (w_inp) begin
                            r_state   <= S_IO_RD;
                            io_rd_stb <= 1'b1;
                            io_port   <= IO_port_ID;
                            r_dest    <= destination_reg_addr;
                        end else begin
                            if (w_regwr) begin
                                rf_wr_en   <= 1'b1;
                                rf_wr_rns  <= destination_reg_addr[3];
                                rf_wr_addr <= destination_reg_addr[2:0];
                                rf_wr_data <= destination_reg_addr[3] ? operation_result
                                                                      : zext8(operation_result[7:0]);
                            end
                            // EX delivers the carry-out qualified by reg_wr_en on a save_cout op.
                            if (w_save) begin
                                carry_flag <= w_regwr;
                            end
                        end
                    end
                end
                default: begin
                    if (w_done || w_tmo) begin
                        r_state   <= S_IDLE;
                        r_wd      <= '0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        io_wr_stb <= 1'b0;
                        io_rd_stb <= 1'b0;
                        if (w_tmo) begin
                            bus_err <= 1'b1;
                        end else if (r_state == S_MEM_RD || r_state == S_IO_RD) begin
                            rf_wr_en   <= 1'b1;
                            rf_wr_rns  <= r_dest[3];
                            rf_wr_addr <= r_dest[2:0];
                            rf_wr_data <= zext8((r_state == S_MEM_RD) ? mem_rdata : io_rdata);
                        end
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pl_mem_wb.sv
// Bench for pl_mem_wb: directed cases followed by random transactions, each checked
// against per-transaction expectations derived from the stage's handshake rules.
module tb_pl_mem_wb;

    localparam int ND  = 2;
    localparam int RW  = ND * 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:9]    EX_reg;
    logic [RW-1:0] operation_result;
    logic [3:0]    destination_reg_addr;
    logic [15:0]   data_op_addr;
    logic [7:0]    IO_port_ID;
    logic [7:0]    mem_rdata;
    logic          mem_ready;
    logic [7:0]    io_rdata;
    logic          io_ack;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we, mem_re;
    logic [7:0]    io_port, io_wdata;
    logic          io_wr_stb, io_rd_stb;
    logic          rf_wr_en, rf_wr_rns;
    logic [2:0]    rf_wr_addr;
    logic [RW-1:0] rf_wr_data;
    logic          carry_flag, stall, bus_err;

    always #5 clk = ~clk;

    pl_mem_wb #(.NUM_DOMAINS(ND), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .EX_reg(EX_reg), .operation_result(operation_result),
        .destination_reg_addr(destination_reg_addr), .data_op_addr(data_op_addr),
        .IO_port_ID(IO_port_ID), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .io_rdata(io_rdata), .io_ack(io_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .io_port(io_port), .io_wdata(io_wdata),
        .io_wr_stb(io_wr_stb), .io_rd_stb(io_rd_stb), .rf_wr_en(rf_wr_en),
        .rf_wr_rns(rf_wr_rns), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .carry_flag(carry_flag), .stall(stall), .bus_err(bus_err)
    );

    int   checks = 0;
    int   failures = 0;
    logic exp_carry = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EX_reg    = '0;
        mem_ready = 1'b0;
        io_ack    = 1'b0;
    endtask

    function automatic logic [0:9] mkex(input logic st, input logic rw, input logic sv,
                                        input logic kl, input logic ld, input logic op,
                                        input logic ip);
        return {st, rw, sv, kl, ld, 1'b0, 1'b0, 1'b0, op, ip};
    endfunction

    function automatic logic [31:0] reqs();
        return 32'({mem_we, mem_re, io_wr_stb, io_rd_stb});
    endfunction

    // lat = wait cycles with ready/ack low before the completing cycle; lat < 0 never completes.
    task automatic do_op(input logic [0:9] ex, input logic [RW-1:0] res, input logic [3:0] dest,
                         input logic [15:0] addr, input logic [7:0] port, input int lat,
                         input logic [7:0] rdat);
        int   kind;
        int   nwait;
        logic acc, rd, mem;
        logic [RW-1:0] exp_data;
        if (ex[3])      kind = 0;
        else if (ex[0]) kind = 4;
        else if (ex[4]) kind = 3;
        else if (ex[8]) kind = 6;
        else if (ex[9]) kind = 5;
        else if (ex[1]) kind = 2;
        else            kind = 1;
        acc = (kind >= 3);
        rd  = (kind == 3 || kind == 5);
        mem = (kind == 3 || kind == 4);

        tick();
        EX_reg = ex; operation_result = res; destination_reg_addr = dest;
        data_op_addr = addr; IO_port_ID = port;
        mem_ready = 1'($urandom_range(0, 1)); io_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom); io_rdata = 8'($urandom);
        #1;
        chk("decode_stall", 32'(stall), 32'(acc));
        chk("decode_req", reqs(), 32'(0));

        if (!acc) begin
            if ((kind == 1 || kind == 2) && ex[2]) exp_carry = ex[1];
            tick(); idle_inputs(); #1;
            chk("wb_en", 32'(rf_wr_en), 32'(kind == 2));
            if (kind == 2) begin
                exp_data = '0;
                exp_data[7:0] = res[7:0];
                if (dest[3]) exp_data = res;
                chk("wb_addr", 32'(rf_wr_addr), 32'(dest[2:0]));
                chk("wb_rns", 32'(rf_wr_rns), 32'(dest[3]));
                chk("wb_data", 32'(rf_wr_data), 32'(exp_data));
            end
            chk("carry", 32'(carry_flag), 32'(exp_carry));
            chk("nop_req", reqs(), 32'(0));
            chk("nop_stall", 32'(stall), 32'(0));
            return;
        end

        nwait = (lat < 0) ? TMO : lat + 1;
        for (int w = 0; w < nwait; w++) begin
            logic last;
            tick();
            last = (lat >= 0) && (w == lat);
            if (mem) begin
                mem_ready = last; io_ack = 1'($urandom_range(0, 1));
            end else begin
                io_ack = last; mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = (last && mem) ? rdat : 8'($urandom);
            io_rdata  = (last && !mem) ? rdat : 8'($urandom);
            #1;
            chk("wait_req", reqs(), 32'({kind == 4, kind == 3, kind == 6, kind == 5}));
            if (mem) chk("mem_addr", 32'(mem_addr), 32'(addr));
            else     chk("io_port", 32'(io_port), 32'(port));
            if (kind == 4) chk("mem_wdata", 32'(mem_wdata), 32'(res[7:0]));
            if (kind == 6) chk("io_wdata", 32'(io_wdata), 32'(res[7:0]));
            if (lat >= 0 || w < TMO - 1) chk("wait_stall", 32'(stall), 32'(!last));
        end

        tick(); idle_inputs(); #1;
        chk("end_req", reqs(), 32'(0));
        chk("end_wb_en", 32'(rf_wr_en), 32'(rd && lat >= 0));
        if (rd && lat >= 0) begin
            chk("ld_addr", 32'(rf_wr_addr), 32'(dest[2:0]));
            chk("ld_rns", 32'(rf_wr_rns), 32'(dest[3]));
            chk("ld_data", 32'(rf_wr_data), 32'(rdat));
        end
        chk("bus_err", 32'(bus_err), 32'(lat < 0));
        chk("end_stall", 32'(stall), 32'(0));
        chk("carry_hold", 32'(carry_flag), 32'(exp_carry));
        tick(); #1;
        chk("pulse_end", 32'({bus_err, rf_wr_en}), 32'(0));
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        operation_result = '0; destination_reg_addr = '0; data_op_addr = '0;
        IO_port_ID = '0; mem_rdata = '0; io_rdata = '0;
        repeat (3) tick();
        chk("rst_ctrl", 32'({mem_we, mem_re, io_wr_stb, io_rd_stb, rf_wr_en, bus_err,
                             carry_flag, stall}), 32'(0));
        chk("rst_data", 32'({mem_addr, rf_wr_data}), 32'(0));
        reset = 1'b0;

        // ALU writeback, then carry set and cleared through save_cout
        do_op(mkex(0, 1, 0, 0, 0, 0, 0), RW'(16'h125A), 4'h3, 16'h0, 8'h0, 0, 8'h0);
        do_op(mkex(0, 1, 1, 0, 0, 0, 0), RW'(16'hBEEF), 4'hB, 16'h0, 8'h0, 0, 8'h0);
        // Load with three idle wait cycles, store completing at once
        do_op(mkex(0, 0, 0, 0, 1, 0, 0), RW'(0), 4'h5, 16'h0120, 8'h0, 3, 8'hC3);
        do_op(mkex(1, 0, 0, 0, 0, 0, 0), RW'(16'h007E), 4'h0, 16'h00FF, 8'h0, 0, 8'h0);
        // Killed ops must leave memory, regfile and carry alone
        do_op(mkex(1, 0, 1, 1, 0, 0, 0), RW'(16'h0011), 4'h2, 16'h0040, 8'h0, 0, 8'h0);
        do_op(mkex(0, 1, 1, 1, 0, 0, 0), RW'(16'h0022), 4'h2, 16'h0, 8'h0, 0, 8'h0);
        do_op(mkex(0, 0, 1, 0, 0, 0, 0), RW'(16'h0), 4'h0, 16'h0, 8'h0, 0, 8'h0);
        // I/O output, input into RNS file, input that never acknowledges
        do_op(mkex(0, 0, 0, 0, 0, 1, 0), RW'(16'h00A5), 4'h0, 16'h0, 8'h31, 1, 8'h0);
        do_op(mkex(0, 0, 0, 0, 0, 0, 1), RW'(0), 4'hE, 16'h0, 8'h07, 2, 8'h9D);
        do_op(mkex(0, 0, 0, 0, 0, 0, 1), RW'(0), 4'h1, 16'h0, 8'h02, -1, 8'h0);
        // Priority: store beats load/outp/inp/reg_wr_en
        do_op(mkex(1, 1, 1, 0, 1, 1, 1), RW'(16'h0044), 4'h6, 16'h1234, 8'h09, 1, 8'h0);

        for (int n = 0; n < 40; n++) begin
            logic [0:9] ex;
            int         lat;
            ex = 10'($urandom);
            if ($urandom_range(0, 5) != 0) ex[3] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                ex[0] = 1'b0; ex[4] = 1'b0; ex[8] = 1'b0; ex[9] = 1'b0;
            end
            lat = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
            do_op(ex, RW'($urandom), 4'($urandom), 16'($urandom), 8'($urandom), lat,
                  8'($urandom));
        end

        // Reset in the middle of a load wait
        do_op(mkex(0, 1, 1, 0, 0, 0, 0), RW'(16'h0001), 4'h1, 16'h0, 8'h0, 0, 8'h0);
        tick();
        EX_reg = mkex(0, 0, 0, 0, 1, 0, 0); data_op_addr = 16'h0300; destination_reg_addr = 4'h2;
        #1;
        chk("rst_ld_stall", 32'(stall), 32'(1));
        tick(); #1;
        chk("rst_ld_req", 32'(mem_re), 32'(1));
        tick(); reset = 1'b1; idle_inputs(); #1;
        chk("rst_sync_hold", 32'(mem_re), 32'(1));
        tick(); reset = 1'b0; mem_ready = 1'b1; mem_rdata = 8'hAA; #1;
        exp_carry = 1'b0;
        chk("rst_drop_req", reqs(), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_no_wb", 32'(rf_wr_en), 32'(0));
        chk("rst_carry", 32'(carry_flag), 32'(exp_carry));
        tick(); #1;
        chk("idle_ready_ignored", 32'({rf_wr_en, mem_re, stall}), 32'(0));
        tick(); idle_inputs(); #1;
        chk("idle_ready_ignored2", 32'({rf_wr_en, mem_re}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
